// File: rtl/store_buffer.sv
// In-order store buffer between write-back and the data cache; drains one store at a time over valid/ready + write-done.
// Optional store-to-load forwarding across all resident entries when STORE_BUFFER_FWD_EN is defined.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                store_ce_i,
  input  logic [ADDR_W-1:0]   store_addr_i,
  input  logic [DATA_W-1:0]   store_data_i,
  input  logic [DATA_W/8-1:0] store_wstrb_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o,
  output logic                cache_req_valid_o,
  input  logic                cache_req_ready_i,
  output logic [ADDR_W-1:0]   cache_req_addr_o,
  output logic [DATA_W-1:0]   cache_req_data_o,
  output logic [DATA_W/8-1:0] cache_req_wstrb_o,
  input  logic                cache_wr_done_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic [DATA_W-1:0]   ld_data_o,
  output logic [DATA_W/8-1:0] ld_wstrb_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = DATA_W / 8;
  localparam int BW = $clog2(SW);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [SW-1:0]     mem_wstrb [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PW-1:0]     wr_ptr, rd_ptr, nxt_rd;
  logic [PW:0]       count, remain;
  state_t            state;
  logic              push, pop, go_req;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [SW-1:0]     head_wstrb;
  logic              unused_fwd;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0) && (state == S_IDLE);
  assign push    = store_ce_i && !full_o;
  assign pop     = (state == S_WAIT) && cache_wr_done_i;
  assign nxt_rd  = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign remain  = count - (PW+1)'(pop);
  assign go_req  = (remain != '0) || push;

  // With no older entry left, the next head is the store being committed this cycle.
  assign head_addr  = (remain != '0) ? mem_addr[nxt_rd]  : store_addr_i;
  assign head_data  = (remain != '0) ? mem_data[nxt_rd]  : store_data_i;
  assign head_wstrb = (remain != '0) ? mem_wstrb[nxt_rd] : store_wstrb_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= store_addr_i;
      mem_data[wr_ptr]  <= store_data_i;
      mem_wstrb[wr_ptr] <= store_wstrb_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      ent_vld           <= '0;
      state             <= S_IDLE;
      overflow_o        <= 1'b0;
      cache_req_valid_o <= 1'b0;
      cache_req_addr_o  <= '0;
      cache_req_data_o  <= '0;
      cache_req_wstrb_o <= '0;
    end else begin
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= nxt_rd;
      end
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (store_ce_i && full_o)
        overflow_o <= 1'b1;

      case (state)
        S_IDLE, S_WAIT: begin
          if (state == S_IDLE || pop) begin
            if (go_req) begin
              state             <= S_REQ;
              cache_req_valid_o <= 1'b1;
              cache_req_addr_o  <= head_addr;
              cache_req_data_o  <= head_data;
              cache_req_wstrb_o <= head_wstrb;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_REQ: begin
          if (cache_req_ready_i) begin
            state             <= S_WAIT;
            cache_req_valid_o <= 1'b0;
          end
        end
        default: begin
          state             <= S_IDLE;
          cache_req_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so later strobes overwrite earlier bytes.
  always_comb begin
    ld_data_o  = '0;
    ld_wstrb_o = '0;
    fwd_idx    = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (ent_vld[fwd_idx] && (mem_addr[fwd_idx][ADDR_W-1:BW] == ld_addr_i[ADDR_W-1:BW])) begin
        for (int b = 0; b < SW; b++) begin
          if (mem_wstrb[fwd_idx][b]) begin
            ld_data_o[b*8 +: 8] = mem_data[fwd_idx][b*8 +: 8];
            ld_wstrb_o[b]       = 1'b1;
          end
        end
      end
    end
  end

  assign ld_hit_o   = (ld_wstrb_o != '0);
  assign unused_fwd = ^ld_addr_i[BW-1:0];
`else
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = '0;
  assign ld_wstrb_o = '0;
  assign unused_fwd = ^{ld_addr_i, ent_vld};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: a queue-based reference model of committed stores checked every cycle.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        store_ce = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  store_wstrb = '0;
  logic        full, empty, overflow;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_wstrb;
  logic        wr_done = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  ld_wstrb;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;

  st_t  q[$];
  bit   outst    = 1'b0;
  bit   ovf      = 1'b0;
  bit   just_rst = 1'b1;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .store_ce_i        (store_ce),
    .store_addr_i      (store_addr),
    .store_data_i      (store_data),
    .store_wstrb_i     (store_wstrb),
    .full_o            (full),
    .empty_o           (empty),
    .overflow_o        (overflow),
    .cache_req_valid_o (req_valid),
    .cache_req_ready_i (req_ready),
    .cache_req_addr_o  (req_addr),
    .cache_req_data_o  (req_data),
    .cache_req_wstrb_o (req_wstrb),
    .cache_wr_done_i   (wr_done),
    .ld_addr_i         (ld_addr),
    .ld_hit_o          (ld_hit),
    .ld_data_o         (ld_data),
    .ld_wstrb_o        (ld_wstrb)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor and reference model: mid-cycle, inputs and outputs are stable for the coming edge.
  always @(negedge clk) begin : monitor
    logic [31:0] ed;
    logic [3:0]  es;
    int          presize;
    if (armed) begin
      check("full", full, q.size() == DEPTH);
      check("empty", empty, q.size() == 0);
      check("overflow", overflow, ovf);
      check("req_valid", req_valid, (q.size() != 0) && !outst);
      if (just_rst) begin
        check("rst_addr", req_addr, 0);
        check("rst_data", req_data, 0);
        check("rst_wstrb", req_wstrb, 0);
        just_rst = 1'b0;
      end
      if (req_valid && q.size() != 0) begin
        check("req_addr", req_addr, q[0].a);
        check("req_data", req_data, q[0].d);
        check("req_wstrb", req_wstrb, q[0].s);
      end

      ed = '0;
      es = '0;
`ifdef STORE_BUFFER_FWD_EN
      foreach (q[i]) begin
        if (q[i].a[31:2] == ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (q[i].s[b]) begin
              ed[b*8 +: 8] = q[i].d[b*8 +: 8];
              es[b]        = 1'b1;
            end
          end
        end
      end
`endif
      check("ld_data", ld_data, ed);
      check("ld_wstrb", ld_wstrb, es);
      check("ld_hit", ld_hit, es != 0);

      if (rst_n) begin
        q.delete();
        outst    = 1'b0;
        ovf      = 1'b0;
        just_rst = 1'b1;
      end else begin
        presize = q.size();
        if (outst && wr_done) begin
          void'(q.pop_front());
          outst = 1'b0;
        end else if (req_valid && req_ready) begin
          outst = 1'b1;
        end
        if (store_ce) begin
          if (presize < DEPTH) q.push_back('{a: store_addr, d: store_data, s: store_wstrb});
          else                 ovf = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    store_ce    = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_wstrb = s;
    step();
    store_ce = 1'b0;
  endtask

  initial begin
    logic [31:0] pool [4];
    pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h2000; pool[3] = 32'h2008;

    step();
    step();
    armed = 1'b1;
    rst_n = 1'b0;
    ld_addr = 32'h1000;

    // single store, full request/done round trip
    put(32'h1000, 32'hDEADBEEF, 4'hF);
    req_ready = 1'b1; step();
    req_ready = 1'b0; step();
    wr_done = 1'b1;   step();
    wr_done = 1'b0;   step();

    // fill with the cache stalled, then overflow
    for (int i = 0; i < 5; i++) put(32'h3000 + 32'(i*4), $urandom, 4'hF);
    step();

    // pop and push together while full: push rejected, retry accepted
    req_ready = 1'b1; step();
    req_ready = 1'b0;
    wr_done = 1'b1;
    put(32'h4000, 32'h01020304, 4'hF);
    wr_done = 1'b0;
    put(32'h4000, 32'h05060708, 4'hF);
    req_ready = 1'b1; wr_done = 1'b1;
    repeat (20) step();

    // six stores through, wrapping the pointers
    for (int i = 0; i < 6; i++) begin
      put(32'h5000 + 32'(i*4), $urandom, 4'(i+1));
      step();
    end
    repeat (20) step();

    // byte merge from two stores to the same word
    req_ready = 1'b0; wr_done = 1'b0;
    ld_addr = 32'h1000;
    put(32'h1000, 32'h11223344, 4'hF);
    put(32'h1000, 32'hAA000000, 4'h8);
    step();
    ld_addr = 32'h2000; step();
    req_ready = 1'b1; wr_done = 1'b1;
    repeat (12) step();

    // reset while waiting for done; the late done must be ignored
    req_ready = 1'b0; wr_done = 1'b0;
    put(32'h6000, 32'hCAFEF00D, 4'h3);
    req_ready = 1'b1; step();
    req_ready = 1'b0; step();
    rst_n = 1'b1; step();
    rst_n = 1'b0; wr_done = 1'b1; step();
    wr_done = 1'b0; step();

    for (int c = 0; c < 1500; c++) begin
      rst_n       = ($urandom_range(0, 199) == 0);
      store_ce    = ($urandom_range(0, 9) < 6);
      store_addr  = pool[$urandom_range(0, 3)];
      store_data  = $urandom;
      store_wstrb = 4'($urandom);
      req_ready   = $urandom_range(0, 1) == 1;
      wr_done     = $urandom_range(0, 1) == 1;
      ld_addr     = pool[$urandom_range(0, 3)];
      step();
    end

    rst_n = 1'b0; store_ce = 1'b0; req_ready = 1'b1; wr_done = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
